// File: rtl/cdf_builder_if.sv
// Handshake/bus bundle between the CDF builder and its pixel source / divider.
// master: pixel source + divider side (drives start, pixels, done).
// slave:  cdf_builder side (drives pix_ready, div_en, cdf_out, cdf_min, bin_idx, busy, frame_done).
interface cdf_builder_if #(
    parameter int LPOW  = 8,
    parameter int CNT_W = 32
);
    logic             start;
    logic             pix_valid;
    logic [LPOW-1:0]  pix_in;
    logic             pix_ready;
    logic             div_en;
    logic             done;
    logic [CNT_W-1:0] cdf_out;
    logic [CNT_W-1:0] cdf_min;
    logic [LPOW-1:0]  bin_idx;
    logic             busy;
    logic             frame_done;

    modport master (
        output start, pix_valid, pix_in, done,
        input  pix_ready, div_en, cdf_out, cdf_min, bin_idx, busy, frame_done
    );

    modport slave (
        input  start, pix_valid, pix_in, done,
        output pix_ready, div_en, cdf_out, cdf_min, bin_idx, busy, frame_done
    );
endinterface

// File: rtl/cdf_builder.sv
// Purpose: per-frame histogram -> in-place CDF -> stream one CDF value per bin to the divider.
// Latency: 2^LPOW clear + SIZE accepted pixels + 2^LPOW scan, then 1 + divider latency per bin.
// Backpressure: pix_ready high only while accumulating; each bin waits in WAIT until done.
// Ports: clk, reset (async active-low), bus (cdf_builder_if.slave: start, pix_valid/pix_in/pix_ready,
//        div_en/done, cdf_out, cdf_min, bin_idx, busy, frame_done).
// Option: define CDF_SKIP_EMPTY_EN to skip bins whose CDF equals the previous bin's (empty bins).
module cdf_builder #(
    parameter int SIZE  = 1600,
    parameter int LPOW  = 8,
    parameter int CNT_W = 32
) (
    input  logic           clk,
    input  logic           reset,
    cdf_builder_if.slave   bus
);
    localparam int NBINS = 1 << LPOW;
    localparam int PCW   = $clog2(SIZE + 1);

    typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, SCAN, EMIT, WAIT} state_t;

    state_t           state;
    logic [CNT_W-1:0] hist [NBINS];
    logic [LPOW-1:0]  idx;          // walks bins during CLEAR and SCAN
    logic [PCW-1:0]   pix_cnt;
    logic [CNT_W-1:0] acc;          // running CDF during SCAN
    logic             min_found;
`ifdef CDF_SKIP_EMPTY_EN
    logic [CNT_W-1:0] prev_cdf;     // CDF of the previous bin; equal value means the bin is empty
`endif

    logic             accept;
    logic [CNT_W-1:0] acc_next;
    logic             hist_we;
    logic [LPOW-1:0]  hist_addr;
    logic [CNT_W-1:0] hist_wdat;

    assign accept   = bus.pix_valid && bus.pix_ready;
    assign acc_next = acc + hist[idx];

    // Single write port shared by CLEAR, ACCUM and SCAN. The read-modify-write in ACCUM
    // completes in one cycle, so identical back-to-back pixels each see the updated count.
    always_comb begin
        hist_we   = 1'b0;
        hist_addr = idx;
        hist_wdat = '0;
        case (state)
            CLEAR: hist_we = 1'b1;
            ACCUM: begin
                if (accept) begin
                    hist_we   = 1'b1;
                    hist_addr = bus.pix_in;
                    hist_wdat = hist[bus.pix_in] + CNT_W'(1);
                end
            end
            SCAN: begin
                hist_we   = 1'b1;
                hist_wdat = acc_next;
            end
            default: ;
        endcase
    end

    // Histogram storage is deliberately not reset; CLEAR zeroes it at the start of each frame.
    always_ff @(posedge clk) begin
        if (hist_we)
            hist[hist_addr] <= hist_wdat;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            idx            <= '0;
            pix_cnt        <= '0;
            acc            <= '0;
            min_found      <= 1'b0;
`ifdef CDF_SKIP_EMPTY_EN
            prev_cdf       <= '0;
`endif
            bus.pix_ready  <= 1'b0;
            bus.div_en     <= 1'b0;
            bus.cdf_out    <= '0;
            bus.cdf_min    <= '0;
            bus.bin_idx    <= '0;
            bus.busy       <= 1'b0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.div_en     <= 1'b0;
            bus.frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state    <= CLEAR;
                        bus.busy <= 1'b1;
                        idx      <= '0;
                    end
                end
                CLEAR: begin
                    idx <= idx + LPOW'(1);
                    if (&idx) begin
                        state         <= ACCUM;
                        bus.pix_ready <= 1'b1;
                        pix_cnt       <= '0;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        pix_cnt <= pix_cnt + PCW'(1);
                        if (pix_cnt == PCW'(SIZE - 1)) begin
                            bus.pix_ready <= 1'b0;
                            state         <= SCAN;
                            acc           <= '0;
                            min_found     <= 1'b0;
                        end
                    end
                end
                SCAN: begin
                    acc <= acc_next;
                    idx <= idx + LPOW'(1);
                    if (!min_found && acc_next != '0) begin
                        bus.cdf_min <= acc_next;
                        min_found   <= 1'b1;
                    end
                    if (&idx) begin
                        state       <= EMIT;
                        bus.bin_idx <= '0;
`ifdef CDF_SKIP_EMPTY_EN
                        prev_cdf    <= '0;
`endif
                    end
                end
                EMIT: begin
`ifdef CDF_SKIP_EMPTY_EN
                    if (hist[bus.bin_idx] == prev_cdf) begin
                        if (&bus.bin_idx) begin
                            bus.frame_done <= 1'b1;
                            bus.busy       <= 1'b0;
                            state          <= IDLE;
                        end else begin
                            bus.bin_idx <= bus.bin_idx + LPOW'(1);
                        end
                    end else begin
                        bus.cdf_out <= hist[bus.bin_idx];
                        prev_cdf    <= hist[bus.bin_idx];
                        bus.div_en  <= 1'b1;
                        state       <= WAIT;
                    end
`else
                    bus.cdf_out <= hist[bus.bin_idx];
                    bus.div_en  <= 1'b1;
                    state       <= WAIT;
`endif
                end
                WAIT: begin
                    if (bus.done) begin
                        if (&bus.bin_idx) begin
                            bus.frame_done <= 1'b1;
                            bus.busy       <= 1'b0;
                            state          <= IDLE;
                        end else begin
                            bus.bin_idx <= bus.bin_idx + LPOW'(1);
                            state       <= EMIT;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cdf_builder.sv
module tb_cdf_builder;
    localparam int SIZE  = 1600;
    localparam int LPOW  = 8;
    localparam int CNT_W = 32;
    localparam int NB    = 1 << LPOW;
    localparam int LONG_BIN = 5;

    typedef struct packed {
        logic [7:0]  bin;
        logic [31:0] cdf;
    } exp_t;

    logic clk;
    logic rst_n;

    cdf_builder_if #(.LPOW(LPOW), .CNT_W(CNT_W)) bus ();

    cdf_builder #(.SIZE(SIZE), .LPOW(LPOW), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_err    = 0;
    int          n_checks = 0;
    exp_t        sbq[$];
    logic [31:0] exp_min  = 0;
    int          exp_div  = 0;
    logic [31:0] seen_cdf [NB];
    int          div_cnt  = 0;
    int          fd_cnt   = 0;
    logic        prev_div = 1'b0;
    logic        prev_fd  = 1'b0;
    logic        long_en  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pix_val(input int mode, input int k);
        if (mode == 0) return 8'(k % 256);
        return (k < 800) ? 8'd10 : 8'd200;
    endfunction

    // Reference histogram/CDF for the frame, pushed before the frame is driven.
    task automatic push_expected(input int mode);
        int h [NB];
        int c;
        int prev;
        int n;
        for (int b = 0; b < NB; b++) h[b] = 0;
        for (int k = 0; k < SIZE; k++) h[pix_val(mode, k)]++;
        c = 0; prev = 0; n = 0; exp_min = 0;
        for (int b = 0; b < NB; b++) begin
            c += h[b];
            if (exp_min == 0 && c != 0) exp_min = c;
`ifdef CDF_SKIP_EMPTY_EN
            if (c != prev) begin
                sbq.push_back('{bin: 8'(b), cdf: c});
                n++;
            end
`else
            sbq.push_back('{bin: 8'(b), cdf: c});
            n++;
`endif
            prev = c;
        end
        exp_div = n;
        for (int b = 0; b < NB; b++) seen_cdf[b] = 32'hFFFF_FFFF;
    endtask

    // Output monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (bus.div_en) begin
            chk("div_en_pulse", prev_div, 0);
            div_cnt++;
            seen_cdf[bus.bin_idx] = bus.cdf_out;
            chk("sb_nonempty", sbq.size() != 0, 1);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("bin_idx", bus.bin_idx, e.bin);
                chk("cdf_out", bus.cdf_out, e.cdf);
                chk("cdf_min", bus.cdf_min, exp_min);
            end
        end
        if (bus.frame_done) begin
            chk("frame_done_pulse", prev_fd, 0);
            chk("frame_done_bin", bus.bin_idx, 255);
            fd_cnt++;
        end
        prev_div = bus.div_en;
        prev_fd  = bus.frame_done;
    end

    // Divider model: answers each div_en with a one-cycle done after a latency.
    initial begin : divider
        bit          pending;
        logic [7:0]  hb;
        logic [31:0] hc;
        int          lat;
        pending  = 0;
        bus.done = 1'b0;
        forever begin
            if (!pending) @(negedge clk);
            pending = 0;
            if (bus.div_en && rst_n) begin
                hb  = bus.bin_idx;
                hc  = bus.cdf_out;
                lat = (long_en && hb == LONG_BIN) ? 40 : 3;
                for (int i = 0; i < lat; i++) begin
                    @(negedge clk);
                    if (lat == 40) begin
                        chk("hold_bin_idx", bus.bin_idx, hb);
                        chk("hold_cdf_out", bus.cdf_out, hc);
                        chk("hold_no_div_en", bus.div_en, 0);
                    end
                end
                bus.done = 1'b1;
                @(negedge clk);
                bus.done = 1'b0;
                if (lat == 40) begin
                    chk("emit_gap", bus.div_en, 0);
                    @(negedge clk);
                    chk("next_div_en", bus.div_en, 1);
                    pending = 1;
                end
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Drive pixels until 'limit' have been accepted; a pixel counts when it was
    // valid while pix_ready (sampled at the previous negedge) was high.
    task automatic send_pixels(input int mode, input bit stalls, input int limit);
        int   k = 0;
        int   g = 0;
        logic rdy_seen = 1'b0;
        while (k < limit && g < 10000) begin
            @(negedge clk);
            g++;
            if (bus.pix_valid && rdy_seen) k++;
            if (k < limit) begin
                rdy_seen      = bus.pix_ready;
                bus.pix_valid = stalls ? 1'($urandom_range(0, 1)) : 1'b1;
                bus.pix_in    = pix_val(mode, k);
            end
        end
        bus.pix_valid = 1'b0;
        chk("pixels_accepted", k, limit);
        if (limit == SIZE) chk("pix_ready_drop", bus.pix_ready, 0);
    endtask

    task automatic wait_frame(input int fd0, input int div0);
        int g = 0;
        while (fd_cnt == fd0 && g < 20000) begin
            @(negedge clk);
            g++;
        end
        chk("frame_completed", fd_cnt != fd0, 1);
        repeat (5) @(negedge clk);
        chk("frame_done_count", fd_cnt - fd0, 1);
        chk("div_en_count", div_cnt - div0, exp_div);
        chk("sb_drained", sbq.size(), 0);
        chk("busy_after_frame", bus.busy, 0);
    endtask

    task automatic ramp_checks();
        chk("ramp_bin0", seen_cdf[0], 7);
        chk("ramp_bin63", seen_cdf[63], 448);
        chk("ramp_bin64", seen_cdf[64], 454);
        chk("ramp_bin255", seen_cdf[255], 1600);
        chk("ramp_cdf_min", bus.cdf_min, 7);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_pix_ready"}, bus.pix_ready, 0);
        chk({tag, "_div_en"}, bus.div_en, 0);
        chk({tag, "_cdf_out"}, bus.cdf_out, 0);
        chk({tag, "_cdf_min"}, bus.cdf_min, 0);
        chk({tag, "_bin_idx"}, bus.bin_idx, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_frame_done"}, bus.frame_done, 0);
    endtask

    initial begin
        int fd0;
        int div0;
        int g;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.pix_valid = 1'b0;
        bus.pix_in    = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Ramp frame with a long divider hold and stray starts during SCAN and WAIT
        push_expected(0);
        long_en = 1'b1;
        fd0 = fd_cnt; div0 = div_cnt;
        pulse_start();
        send_pixels(0, 0, SIZE);
        chk("busy_in_scan", bus.busy, 1);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        g = 0;
        while (div_cnt < div0 + 3 && g < 5000) begin
            @(negedge clk);
            g++;
        end
        chk("reached_emit", div_cnt >= div0 + 3, 1);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_frame(fd0, div0);
        ramp_checks();
        long_en = 1'b0;

        // Ramp frame with random pix_valid stalls
        push_expected(0);
        fd0 = fd_cnt; div0 = div_cnt;
        pulse_start();
        send_pixels(0, 1, SIZE);
        wait_frame(fd0, div0);
        ramp_checks();

        // Two-value frame
        push_expected(1);
        fd0 = fd_cnt; div0 = div_cnt;
        pulse_start();
        send_pixels(1, 0, SIZE);
        wait_frame(fd0, div0);
        chk("two_cdf_min", bus.cdf_min, 800);
        chk("two_bin10", seen_cdf[10], 800);
        chk("two_bin200", seen_cdf[200], 1600);
`ifdef CDF_SKIP_EMPTY_EN
        chk("two_div_en_count", div_cnt - div0, 2);
`else
        chk("two_bin9", seen_cdf[9], 0);
        chk("two_bin199", seen_cdf[199], 800);
`endif

        // Abort mid-ACCUM after 500 pixels
        fd0 = fd_cnt;
        pulse_start();
        send_pixels(0, 0, 500);
        #2 rst_n = 1'b0;
        #1 check_all_zero("abort");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_no_frame_done", fd_cnt - fd0, 0);
        chk("abort_idle", bus.busy, 0);

        // Full ramp after abort: no stale counts
        push_expected(0);
        fd0 = fd_cnt; div0 = div_cnt;
        pulse_start();
        send_pixels(0, 0, SIZE);
        wait_frame(fd0, div0);
        ramp_checks();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/cdf_builder.md
Name: cdf_builder

Overview:
- Upstream feeder of the histogram-equalisation divider stage.
- Accumulates a 2^LPOW-bin histogram over one frame of SIZE pixels, then converts it in place to a cumulative distribution (CDF) and captures cdf_min, the first non-zero CDF value.
- Streams one CDF value per bin to the divider with a div_en / done handshake, so every bin's equalised grey level is produced.

Parameters:
- SIZE, 1600, pixels per frame. Also the divider's denominator base.
- LPOW, 8, log2 of the bin count. Pixel width is LPOW bits; there are 2^LPOW bins.
- CNT_W, 32, width of bin counters, cdf_out and cdf_min.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse that begins a frame. Ignored unless the FSM is in IDLE.
- pix_valid  input  1  pix_in is valid this cycle.
- pix_in  input  LPOW  pixel value, used as the bin index.
- pix_ready  output  1  high only in ACCUM. A pixel is accepted when pix_valid && pix_ready.
- div_en  output  1  one-cycle pulse: cdf_out and cdf_min are valid for the divider.
- done  input  1  divider result ready (the divider's ready_g_out).
- cdf_out  output  CNT_W  CDF of bin bin_idx.
- cdf_min  output  CNT_W  first non-zero CDF value of the frame.
- bin_idx  output  LPOW  bin currently presented to the divider.
- busy  output  1  FSM not in IDLE.
- frame_done  output  1  one-cycle pulse when the last bin's done is received.

Behaviour:
- One clock. Reset is asynchronous and active-low.
- Reset clears the FSM to IDLE and zeroes all outputs and counters: pix_ready=0, div_en=0, cdf_out=0, cdf_min=0, bin_idx=0, busy=0, frame_done=0.
- The histogram array is 2^LPOW x CNT_W registers with combinational read. It is not reset; CLEAR zeroes it.
- FSM states:
  - IDLE: start -> CLEAR.
  - CLEAR: zeroes one bin per cycle for 2^LPOW cycles, then -> ACCUM.
  - ACCUM: pix_ready=1. Each accepted pixel does hist[pix_in] += 1 in one cycle. Back-to-back identical values must each count, which the register array handles with no hazard. After exactly SIZE accepted pixels, pix_ready drops in the same cycle the SIZE-th pixel is accepted, and the FSM goes -> SCAN. Gaps in pix_valid stall the count only.
  - SCAN: one bin per cycle, i = 0..2^LPOW-1. acc += hist[i], then hist[i] <= acc. On the first i where acc becomes non-zero, cdf_min <= acc. Lasts 2^LPOW cycles, then -> EMIT.
  - EMIT: load bin_idx and cdf_out = hist[bin_idx], pulse div_en for one cycle, then -> WAIT.
  - WAIT: cdf_out, cdf_min and bin_idx are held stable. On done: if this was the last bin, pulse frame_done and go -> IDLE; otherwise increment bin_idx and go -> EMIT.
- Each bin costs 1 + divider-latency cycles.
- done received outside WAIT is ignored.
- start received while busy is ignored.
- Reset asserted mid-operation aborts the frame immediately. No frame_done is issued. The next start re-clears the histogram.
- Arithmetic: counts never exceed SIZE, so there is no overflow at CNT_W=32. The final CDF equals SIZE.
- All pixels in a single bin gives cdf_min = SIZE. The divider denominator is then 0; this block does not guard it, and the downstream result is don't-care.

Optional Feature:
- Macro: CDF_SKIP_EMPTY_EN.
- Defined: EMIT skips any bin whose CDF equals the previous bin's CDF (treated as 0 for bin 0), i.e. bins with an empty histogram. No div_en is issued for a skipped bin; bin_idx advances one bin per cycle. frame_done still pulses after the last bin, including when that bin is skipped.
- Undefined: all 2^LPOW bins are emitted in order.

Test Plan:
- Ramp frame: pixel k = k mod 256, SIZE=1600. Required: bins 0..63 count 7, bins 64..255 count 6, cdf_min=7, cdf_out(bin 63)=448, cdf_out(bin 255)=1600, 256 div_en pulses, one frame_done.
- Two-value frame: 800 pixels of value 10 and 800 of value 200. Without the macro: bins 0..9 cdf 0, bin 10 cdf 800, bin 200 cdf 1600, cdf_min=800. With CDF_SKIP_EMPTY_EN: exactly 2 div_en pulses, with bin_idx 10 and 200.
- Handshake: hold done low for 40 cycles after a div_en. Required: cdf_out and bin_idx unchanged, no second div_en; the next div_en comes 1 cycle after done.
- Pixel stalls: pix_valid toggles 1/0 randomly. Required: exactly 1600 pixels accepted, pix_ready falls on the 1600th, histogram identical to the ramp case.
- Reset mid-ACCUM after 500 pixels. Required: all outputs 0 asynchronously, state IDLE, no frame_done. A following start and full ramp frame reproduces the ramp results exactly, with no stale counts.
- start pulsed during SCAN and WAIT. Required: ignored, frame completes normally with a single frame_done.
